// File: rtl/regfile_mp.sv
// Multi-ported register file with a per-register scoreboard of pending results.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   re, raddr           per read port enable and address (NRD ports)
//   rdata, rbusy        per read port data and operand-pending flag
//   we, waddr, wdata    per write port enable, address, data (NWR ports)
//   sb_set, sb_addr     per port scoreboard mark of an issued destination
//   flush               clears every pending mark at the next edge
module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NRD    = 4,
    parameter int NWR    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NRD-1:0]        re,
    input  logic [NRD*ADDR_W-1:0] raddr,
    output logic [NRD*DATA_W-1:0] rdata,
    output logic [NRD-1:0]        rbusy,
    input  logic [NWR-1:0]        we,
    input  logic [NWR*ADDR_W-1:0] waddr,
    input  logic [NWR*DATA_W-1:0] wdata,
    input  logic [NWR-1:0]        sb_set,
    input  logic [NWR*ADDR_W-1:0] sb_addr,
    input  logic                  flush
);

    localparam int NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_regs [NREG];
    logic [NREG-1:0]   r_busy;
    logic [NREG-1:0]   w_busy_nxt;
    logic [NRD*DATA_W-1:0] w_rdata;
    logic [NRD-1:0]        w_rbusy;

    // Writes clear first, then marks set, so a same-cycle mark wins:
    // it names a newer producer than the result being written back.
    always_comb begin
        w_busy_nxt = r_busy;
        for (int w = 0; w < NWR; w++) begin
            if (we[w])
                w_busy_nxt[waddr[w*ADDR_W +: ADDR_W]] = 1'b0;
        end
        for (int w = 0; w < NWR; w++) begin
            if (sb_set[w])
                w_busy_nxt[sb_addr[w*ADDR_W +: ADDR_W]] = 1'b1;
        end
        if (flush)
            w_busy_nxt = '0;
        w_busy_nxt[0] = 1'b0;
    end

    // Ascending port loop: the youngest (highest-index) write lands last.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NREG; k++)
                r_regs[k] <= '0;
            r_busy <= '0;
        end else begin
            for (int w = 0; w < NWR; w++) begin
                if (we[w] && (waddr[w*ADDR_W +: ADDR_W] != '0))
                    r_regs[waddr[w*ADDR_W +: ADDR_W]] <=
                        wdata[w*DATA_W +: DATA_W];
            end
            r_busy <= w_busy_nxt;
        end
    end

    // Combinational read with write-through; a bypass hit means the
    // operand is arriving now, so it is no longer reported busy.
    always_comb begin
        w_rdata = '0;
        w_rbusy = '0;
        for (int i = 0; i < NRD; i++) begin
            if (!rst && re[i] && (raddr[i*ADDR_W +: ADDR_W] != '0)) begin
                w_rdata[i*DATA_W +: DATA_W] =
                    r_regs[raddr[i*ADDR_W +: ADDR_W]];
                w_rbusy[i] = r_busy[raddr[i*ADDR_W +: ADDR_W]];
                for (int w = 0; w < NWR; w++) begin
                    if (we[w] && (waddr[w*ADDR_W +: ADDR_W] ==
                                  raddr[i*ADDR_W +: ADDR_W])) begin
                        w_rdata[i*DATA_W +: DATA_W] =
                            wdata[w*DATA_W +: DATA_W];
                        w_rbusy[i] = 1'b0;
                    end
                end
            end
        end
    end

    assign rdata = w_rdata;
    assign rbusy = w_rbusy;

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter DATA_W, default 32, register data width in bits.
REQ-002 Parameter ADDR_W, default 5, register address width; register count NREG = 2**ADDR_W.
REQ-003 Parameter NRD, default 4, number of read ports.
REQ-004 Parameter NWR, default 2, number of write ports; port index order = program order, highest index youngest.
REQ-005 The block SHALL use one clock, and its reset SHALL be asynchronous and active-high.
REQ-006 clk  in  1  clock; all state updates on rising edge.
REQ-007 rst  in  1  asynchronous active-high reset.
REQ-008 re  in  NRD  per-port read enable.
REQ-009 raddr  in  NRD*ADDR_W  read addresses; port i at [i*ADDR_W +: ADDR_W].
REQ-010 rdata  out  NRD*DATA_W  read data; port i at [i*DATA_W +: DATA_W].
REQ-011 rbusy  out  NRD  per-port flag: operand not yet available (scoreboard pending).
REQ-012 we  in  NWR  per-port write enable.
REQ-013 waddr  in  NWR*ADDR_W  write addresses.
REQ-014 wdata  in  NWR*DATA_W  write data.
REQ-015 sb_set  in  NWR  per-port scoreboard mark: destination issued, result pending.
REQ-016 sb_addr  in  NWR*ADDR_W  scoreboard mark addresses.
REQ-017 flush  in  1  synchronous clear of all scoreboard busy bits.

Function
REQ-018 Register 0 SHALL read as 0, never be written, and never be marked busy.
REQ-019 On a clock edge, each port with we=1 and waddr!=0 SHALL write wdata into its register.
REQ-020 Multiple write ports targeting the same address in one cycle: the highest-index port's data SHALL be stored.
REQ-021 Read is combinational; re=0 or raddr=0 SHALL drive rdata=0 and rbusy=0 for that port.
REQ-022 Write-through bypass: if any write port has we=1 and waddr==raddr!=0, rdata SHALL equal the wdata of the highest-index matching port; otherwise rdata is the stored value.
REQ-023 One busy bit per register; on a clock edge, a register's busy bit SHALL be cleared by any we=1 to it and set by any sb_set=1 to it.
REQ-024 Set and clear of the same register in the same cycle: set SHALL win (newer producer outstanding).
REQ-025 flush=1 SHALL clear all busy bits at the edge and override any same-cycle sb_set; register contents and writes are unaffected.
REQ-026 rbusy for an enabled port SHALL be busy[raddr] AND NOT (same-cycle bypass hit on raddr); same-cycle sb_set SHALL NOT affect current-cycle rbusy.
REQ-027 Read-port count, write-port count and widths SHALL follow parameters with no fixed limits; NRD>=1, NWR>=1.
REQ-028 Write ports and scoreboard ports are independent; sb_set without later write leaves busy set until write, flush or reset.

Reset
REQ-029 While rst=1, all registers SHALL be 0, all busy bits 0, and rdata and rbusy outputs 0 on every port, independent of clk.
REQ-030 Reset asserted mid-cycle SHALL discard that cycle's writes and marks; first update occurs on the first rising edge after rst deasserts.

Verification
REQ-031 Write port0 r5=0x12345678, next cycle read port0 r5 -> rdata=0x12345678, rbusy=0.
REQ-032 Same cycle we0 r7=0xAAAA0000 and we1 r7=0x0000BBBB with read r7 -> rdata=0x0000BBBB combinationally; next cycle stored r7=0x0000BBBB.
REQ-033 Write r0=0xFFFFFFFF on both ports plus sb_set r0 -> r0 reads 0, rbusy=0.
REQ-034 sb_set r3 at cycle N -> rbusy(r3)=1 from N+1; at cycle M we r3=0x55 -> rbusy=0 and rdata=0x55 in cycle M; same-cycle we r3 and sb_set r3 -> rbusy(r3)=1 next cycle.
REQ-035 Mark r4,r9 busy, assert flush with sb_set r9 -> both rbusy 0 next cycle.
REQ-036 Fill r1..r31 with distinct values, assert rst asynchronously between edges -> all rdata=0 immediately and after deassert until rewritten.
